// File: rtl/pc_sequencer.sv
// pc_sequencer: 8-bit program-counter sequencer for the DSP fetch path.
// Selects the next PC from the external incrementer result (pc_inc), a
// jump/call target, or the top of a small return-address stack. The block
// never adds 1 itself; the sequential path always goes through pc_inc.
module pc_sequencer #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [7:0] RESET_PC    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  input  logic       jump,
  input  logic       call,
  input  logic       ret,
  input  logic       halt,
  input  logic [7:0] jump_addr,
  input  logic [7:0] pc_inc,
  output logic [7:0] pc,
  output logic       pc_valid,
  output logic       halted,
  output logic       stack_err
);

  // Stack index width and stack-pointer width (sp counts 0..STACK_DEPTH).
  localparam int IDXW = $clog2(STACK_DEPTH);
  localparam int SPW  = IDXW + 1;

  localparam logic [SPW-1:0] SP_ZERO = SPW'(0);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        pc_r;
  logic [7:0]        pc_s;
  logic [SPW-1:0]    sp_r;
  logic [SPW-1:0]    sp_s;
  logic              stack_err_r;
  logic              stack_err_s;
  logic              push_s;
  logic [IDXW-1:0]   push_idx_s;
  logic [IDXW-1:0]   top_idx_s;
  logic [7:0]        stack_r [STACK_DEPTH];

  // Push goes to stack[sp]; the top of stack lives at stack[sp-1]. Both are
  // only used when sp is in range, so truncation to the index width is safe.
  assign push_idx_s = IDXW'(sp_r);
  assign top_idx_s  = IDXW'(sp_r - SP_ONE);

  // Next-state, next-PC and stack-pointer selection; Halt > Ret > Call > Jump > sequential.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    sp_s        = sp_r;
    stack_err_s = stack_err_r;
    push_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pc_s = RESET_PC;
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stall) begin
          state_s = ST_RUN;
        end else if (halt) begin
          state_s = ST_HALT;
        end else if (ret) begin
          if (sp_r == SP_ZERO) begin
            stack_err_s = 1'b1;
            state_s     = ST_HALT;
          end else begin
            pc_s = stack_r[top_idx_s];
            sp_s = sp_r - SP_ONE;
          end
        end else if (call) begin
          if (sp_r == SP_FULL) begin
            stack_err_s = 1'b1;
            state_s     = ST_HALT;
          end else begin
            push_s = 1'b1;
            sp_s   = sp_r + SP_ONE;
            pc_s   = jump_addr;
          end
        end else if (jump) begin
          pc_s = jump_addr;
        end else begin
          pc_s = pc_inc;
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = RESET_PC;
      end
    endcase
  end

  // Control registers: state, PC, stack pointer and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      sp_r        <= SP_ZERO;
      stack_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      sp_r        <= sp_s;
      stack_err_r <= stack_err_s;
    end
  end

  // Return-address storage; contents are meaningless after reset, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[push_idx_s] <= pc_inc;
    end
  end

  // Outputs come straight from registers or decoded registered state.
  assign pc        = pc_r;
  assign pc_valid  = (state_r == ST_RUN);
  assign halted    = (state_r == ST_HALT);
  assign stack_err = stack_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized requests, compared against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int DEPTH = 4;
  localparam int RST_PC = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       jump = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic [7:0] inc_step = 8'h01;
  logic [7:0] pc_inc;
  logic [7:0] pc;
  logic       pc_valid;
  logic       halted;
  logic       stack_err;

  int n_checks = 0;
  int n_pass = 0;

  // Behavioural model: 0 = idle, 1 = run, 2 = halt
  int m_state;
  int m_pc;
  int m_err;
  int m_stack[$];

  pc_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .jump      (jump),
    .call      (call),
    .ret       (ret),
    .halt      (halt),
    .jump_addr (jump_addr),
    .pc_inc    (pc_inc),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .halted    (halted),
    .stack_err (stack_err)
  );

  // External incrementer stage (step is normally 1)
  assign pc_inc = pc + inc_step;

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"},        int'(pc),        m_pc);
    check({tag, ".pc_valid"},  int'(pc_valid),  (m_state == 1) ? 1 : 0);
    check({tag, ".halted"},    int'(halted),    (m_state == 2) ? 1 : 0);
    check({tag, ".stack_err"}, int'(stack_err), m_err);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = RST_PC;
    m_err   = 0;
    m_stack.delete();
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int nxt;
    nxt = (m_pc + int'(inc_step)) % 256;
    if (m_state == 0) begin
      m_pc = RST_PC;
      if (start) m_state = 1;
    end else if (m_state == 1 && !stall) begin
      if (halt) begin
        m_state = 2;
      end else if (ret) begin
        if (m_stack.size() == 0) begin
          m_err = 1; m_state = 2;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (call) begin
        if (m_stack.size() == DEPTH) begin
          m_err = 1; m_state = 2;
        end else begin
          m_stack.push_back(nxt);
          m_pc = int'(jump_addr);
        end
      end else if (jump) begin
        m_pc = int'(jump_addr);
      end else begin
        m_pc = nxt;
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input bit s, input bit sl, input bit j, input bit c,
                       input bit r, input bit h, input logic [7:0] a);
    start = s; stall = sl; jump = j; call = c; ret = r; halt = h; jump_addr = a;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Assert reset between clock edges, check it acts immediately, then release.
  task automatic do_reset(input string tag);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    rst_n = 1'b1;
  endtask

  task automatic start_run(input string tag);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(tag);
    idle_inputs();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;

    // Reset, start, free run, then mid-run async reset
    do_reset("rst0");
    step("idle");
    start_run("start");
    for (int i = 0; i < 5; i++) step("free");
    check("free.pc5", int'(pc), 5);
    do_reset("midrst");

    // Jump near the top of the address space and wrap
    start_run("start2");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
    step("jmpFE");
    idle_inputs();
    for (int i = 0; i < 3; i++) step("wrap");
    check("wrap.pc", int'(pc), 1);

    // Nested call/return
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10); step("jmp10");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40); step("call40");
    idle_inputs();                                    step("seq41");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80); step("call80");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); step("ret1");
    check("ret1.pc", int'(pc), 8'h42);
    step("ret2");
    idle_inputs();                                    step("seq12");
    check("callret.pc", int'(pc), 8'h12);

    // Overflow after DEPTH nested calls
    do_reset("rst_ovf");
    start_run("start3");
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h50 + 8'(i * 16)));
      step("ncall");
    end
    check("ovf.err", int'(stack_err), 1);
    idle_inputs();
    step("ovf.hold");

    // Underflow on an empty stack
    do_reset("rst_unf");
    start_run("start4");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step("unf");
    check("unf.halted", int'(halted), 1);

    // Stall with jump held, then release
    do_reset("rst_stall");
    start_run("start5");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20); step("jmp20");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    for (int i = 0; i < 3; i++) step("stall");
    check("stall.pc", int'(pc), 8'h20);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55); step("unstall");
    check("unstall.pc", int'(pc), 8'h55);

    // Halt has top priority; start does not leave HALT
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h29); step("jmp29");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30); step("call30");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77); step("hrc");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step("halt.start1");
    step("halt.start2");
    check("halt.pc", int'(pc), 8'h30);

    // Sequential PC must come from the incrementer, not an internal +1
    do_reset("rst_inc");
    start_run("start6");
    inc_step = 8'h03;
    for (int i = 0; i < 3; i++) step("inc3");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA0); step("inc3.call");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); step("inc3.ret");
    inc_step = 8'h01;
    idle_inputs();
    step("inc1");

    // Randomized requests
    do_reset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      if (m_state == 2 && $urandom_range(0, 3) == 0) begin
        do_reset("rand.rst");
      end else begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0,
              8'($urandom_range(0, 255)));
        step("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
